chan_regs: RTL and testbench

CHAN_REGS -- requirements
Module: chan_regs

---
 rtl/chan_regs.sv | 209 ++++++++++++++++++++
 tb/tb_chan_regs.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chan_regs.sv
// Channel register block: bus-mapped control, TDM snapshot capture, staged frame commit,
// saturating error counters and per-channel gain/balance. Define CHAN_REGS_IRQ_EN for IRQ regs.
module chan_regs #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  val,
    input  logic [9:0]            addr,
    input  logic                  write,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  tdm2p_en,
    output logic [7:0]            tdm2p_clk_mask,
    output logic [7:0]            tdm2p_clk_patt,
    input  logic                  tdm2p_valid,
    input  logic [32*NUM_CH-1:0]  tdm2p_pdata,
    output logic                  p2tdm_en,
    input  logic                  p2tdm_retrans_incr,
    input  logic                  p2tdm_dropped_incr,
    output logic                  p2tdm_valid,
    output logic [32*NUM_CH-1:0]  p2tdm_pdata,
    output logic [8*NUM_CH-1:0]   gain,
    output logic [8*NUM_CH-1:0]   bal,
    output logic                  sel,
    output logic                  irq
);

    localparam logic [31:0]      BadVal  = 32'hBADA_CE55;
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [9:0]       SnapEnd = 10'(16 + 4 * NUM_CH);
    localparam logic [9:0]       StagEnd = 10'(272 + 4 * NUM_CH);
    localparam logic [9:0]       GbEnd   = 10'(512 + 4 * NUM_CH);

    logic              ready_q;
    logic [31:0]       rdata_q;
    logic              tdm2p_en_q;
    logic [7:0]        mask_q, patt_q;
    logic              p2tdm_en_q, p2tdm_valid_q, sel_q;
    logic [31:0]       snap_q [NUM_CH];
    logic [31:0]       stag_q [NUM_CH];
    logic [7:0]        gain_q [NUM_CH];
    logic [7:0]        bal_q  [NUM_CH];
    logic [CNT_W-1:0]  ret_q, ret_d, drp_q, drp_d;

    logic        acc, wr, capture;
    logic        snap_hit, stag_hit, gb_hit;
    logic [4:0]  snap_idx, stag_idx, gb_idx;
    logic [31:0] rd_val;

    assign acc     = val && !ready_q;
    assign wr      = acc && write;
    assign capture = tdm2p_valid && tdm2p_en_q;

    always_comb begin
        snap_hit = (addr >= 10'h010) && (addr < SnapEnd) && (addr[1:0] == 2'b00);
        stag_hit = (addr >= 10'h110) && (addr < StagEnd) && (addr[1:0] == 2'b00);
        gb_hit   = (addr >= 10'h200) && (addr < GbEnd) && (addr[1:0] == 2'b00);
        snap_idx = 5'((addr - 10'h010) >> 2);
        stag_idx = 5'((addr - 10'h110) >> 2);
        gb_idx   = 5'((addr - 10'h200) >> 2);
    end

`ifdef CHAN_REGS_IRQ_EN
    logic [1:0] stat_q, stat_d, irq_en_q, irq_en_d;
    logic       irq_q, irq_d;
`endif

    // Read value is taken from current state, so a same-cycle capture is not yet visible.
    always_comb begin
        rd_val = BadVal;
        if (addr == 10'h000) begin
            rd_val = {tdm2p_en_q, 15'b0, mask_q, patt_q};
        end else if (snap_hit) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (snap_idx == 5'(i)) rd_val = snap_q[i];
            end
        end else if (addr == 10'h100) begin
            rd_val = {p2tdm_en_q, 31'b0};
        end else if (addr == 10'h104) begin
            rd_val = {16'(ret_q), 16'(drp_q)};
        end else if (stag_hit) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (stag_idx == 5'(i)) rd_val = stag_q[i];
            end
        end else if (gb_hit) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (gb_idx == 5'(i)) rd_val = {16'b0, bal_q[i], gain_q[i]};
            end
        end else if (addr == 10'h300) begin
            rd_val = {31'b0, sel_q};
`ifdef CHAN_REGS_IRQ_EN
        end else if (addr == 10'h304) begin
            rd_val = {30'b0, stat_q};
        end else if (addr == 10'h308) begin
            rd_val = {30'b0, irq_en_q};
`endif
        end
    end

    // Bus write beats a same-cycle increment; otherwise count up and hold at max.
    always_comb begin
        ret_d = ret_q;
        drp_d = drp_q;
        if (wr && addr == 10'h104) begin
            ret_d = wdata[16 +: CNT_W];
            drp_d = wdata[0 +: CNT_W];
        end else begin
            if (p2tdm_retrans_incr && ret_q != CntMax) ret_d = ret_q + 1'b1;
            if (p2tdm_dropped_incr && drp_q != CntMax) drp_d = drp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q       <= 1'b0;
            rdata_q       <= '0;
            tdm2p_en_q    <= 1'b0;
            mask_q        <= '0;
            patt_q        <= '0;
            p2tdm_en_q    <= 1'b0;
            p2tdm_valid_q <= 1'b0;
            sel_q         <= 1'b0;
            ret_q         <= '0;
            drp_q         <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                snap_q[i] <= '0;
                stag_q[i] <= '0;
                gain_q[i] <= '0;
                bal_q[i]  <= '0;
            end
        end else begin
            ready_q       <= acc;
            rdata_q       <= acc ? (write ? wdata : rd_val) : '0;
            p2tdm_valid_q <= wr && (addr == 10'h100) && wdata[0];
            ret_q         <= ret_d;
            drp_q         <= drp_d;
            if (wr && addr == 10'h000) begin
                tdm2p_en_q <= wdata[31];
                mask_q     <= wdata[15:8];
                patt_q     <= wdata[7:0];
            end
            if (wr && addr == 10'h100) p2tdm_en_q <= wdata[31];
            if (wr && addr == 10'h300) sel_q <= wdata[0];
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (capture) snap_q[i] <= tdm2p_pdata[32*i +: 32];
                if (wr && stag_hit && stag_idx == 5'(i)) stag_q[i] <= wdata;
                if (wr && gb_hit && gb_idx == 5'(i)) begin
                    gain_q[i] <= wdata[7:0];
                    bal_q[i]  <= wdata[15:8];
                end
            end
        end
    end

`ifdef CHAN_REGS_IRQ_EN
    // Event set is applied after the W1C clear so it wins; irq tracks the next-state values.
    always_comb begin
        stat_d   = stat_q;
        irq_en_d = irq_en_q;
        if (wr && addr == 10'h304) stat_d = stat_q & ~wdata[1:0];
        if (wr && addr == 10'h308) irq_en_d = wdata[1:0];
        if (capture) stat_d[0] = 1'b1;
        if ((ret_d == CntMax && ret_q != CntMax) || (drp_d == CntMax && drp_q != CntMax)) begin
            stat_d[1] = 1'b1;
        end
        irq_d = |(stat_d & irq_en_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            stat_q   <= stat_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        p2tdm_pdata = '0;
        gain        = '0;
        bal         = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            p2tdm_pdata[32*i +: 32] = stag_q[i];
            gain[8*i +: 8]          = gain_q[i];
            bal[8*i +: 8]           = bal_q[i];
        end
    end

    assign ready          = ready_q;
    assign rdata          = rdata_q;
    assign tdm2p_en       = tdm2p_en_q;
    assign tdm2p_clk_mask = mask_q;
    assign tdm2p_clk_patt = patt_q;
    assign p2tdm_en       = p2tdm_en_q;
    assign p2tdm_valid    = p2tdm_valid_q;
    assign sel            = sel_q;

endmodule

// File: tb/tb_chan_regs.sv
// Scoreboard bench for chan_regs: stimulus queues expected bus responses and sampled
// output checks; a negedge monitor is the only process that compares and counts.
module tb_chan_regs;
    localparam int NCH = 8;

    logic              clk = 1'b0;
    logic              rst, val, write;
    logic [9:0]        addr;
    logic [31:0]       wdata, rdata;
    logic              ready, tdm2p_en, tdm2p_valid, p2tdm_en, p2tdm_valid, sel, irq;
    logic [7:0]        mask, patt;
    logic [32*NCH-1:0] tdm_pdata, p2_pdata;
    logic              rincr, dincr;
    logic [8*NCH-1:0]  gain, bal;

    chan_regs #(.NUM_CH(NCH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .val(val), .addr(addr), .write(write), .wdata(wdata),
        .rdata(rdata), .ready(ready), .tdm2p_en(tdm2p_en), .tdm2p_clk_mask(mask),
        .tdm2p_clk_patt(patt), .tdm2p_valid(tdm2p_valid), .tdm2p_pdata(tdm_pdata),
        .p2tdm_en(p2tdm_en), .p2tdm_retrans_incr(rincr), .p2tdm_dropped_incr(dincr),
        .p2tdm_valid(p2tdm_valid), .p2tdm_pdata(p2_pdata), .gain(gain), .bal(bal),
        .sel(sel), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    logic [31:0] exp_q [$];
    dchk_t       dq [$];
    int          total = 0;
    int          bad = 0;
    int          ready_cnt = 0;
    int          vcnt = 0;
    logic [31:0] vword = '0;

    always @(negedge clk) begin
        while (dq.size() > 0) begin
            dchk_t d;
            d = dq.pop_front();
            total++;
            if (d.act !== d.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", d.name, d.act, d.exp);
            end
        end
        if (ready === 1'b1) begin
            ready_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready: got rdata %h want no response", rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL rdata: got %h want %h", rdata, e);
                end
            end
        end else begin
            total++;
            if (rdata !== 32'h0) begin
                bad++;
                $display("FAIL rdata_idle: got %h want 00000000", rdata);
            end
        end
        if (p2tdm_valid === 1'b1) begin
            vcnt++;
            vword = p2_pdata[95:64];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dq.push_back(d);
    endtask

    // side = {tdm2p_valid, retrans_incr, dropped_incr} asserted during the acceptance cycle
    task automatic bus(input logic [9:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] exp, input logic [2:0] side);
        exp_q.push_back(exp);
        val = 1'b1; addr = a; write = w; wdata = d;
        {tdm2p_valid, rincr, dincr} = side;
        @(posedge clk); #1;
        val = 1'b0; write = 1'b0;
        {tdm2p_valid, rincr, dincr} = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic pulse_capture();
        tdm2p_valid = 1'b1;
        @(posedge clk); #1;
        tdm2p_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        rst = 1'b1; val = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        tdm2p_valid = 1'b0; rincr = 1'b0; dincr = 1'b0;
        for (int i = 0; i < NCH; i++) tdm_pdata[32*i +: 32] = 32'h1000_0000 + i;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tdm2p_en", {31'b0, tdm2p_en}, 0);
        chk("rst_mask_patt", {16'b0, mask, patt}, 0);
        chk("rst_p2tdm_en_sel_irq", {29'b0, p2tdm_en, sel, irq}, 0);
        chk("rst_ready", {31'b0, ready}, 0);
        rst = 1'b0;

        // first request right after reset release
        bus(10'h000, 1'b1, 32'h8000_A55A, 32'h8000_A55A, 3'b000);
        chk("ctrl_en", {31'b0, tdm2p_en}, 1);
        chk("ctrl_mask", {24'b0, mask}, 32'hA5);
        chk("ctrl_patt", {24'b0, patt}, 32'h5A);
        bus(10'h000, 1'b0, 0, 32'h8000_A55A, 3'b000);

        // snapshot capture
        tdm_pdata[127:96] = 32'h1234_5678;
        pulse_capture();
        bus(10'h01C, 1'b0, 0, 32'h1234_5678, 3'b000);
        bus(10'h010, 1'b0, 0, 32'h1000_0000, 3'b000);
        bus(10'h000, 1'b1, 32'h0, 32'h0, 3'b000);
        tdm_pdata[127:96] = 32'hDEAD_BEEF;
        pulse_capture();
        bus(10'h01C, 1'b0, 0, 32'h1234_5678, 3'b000);
        bus(10'h000, 1'b1, 32'h8000_0000, 32'h8000_0000, 3'b000);
        tdm_pdata[127:96] = 32'h55AA_55AA;
        bus(10'h01C, 1'b0, 0, 32'h1234_5678, 3'b100);
        bus(10'h01C, 1'b0, 0, 32'h55AA_55AA, 3'b000);
        bus(10'h01C, 1'b1, 32'h0, 32'h0, 3'b000);
        bus(10'h01C, 1'b0, 0, 32'h55AA_55AA, 3'b000);

        // staging and commit
        bus(10'h118, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 3'b000);
        bus(10'h100, 1'b1, 32'h8000_0001, 32'h8000_0001, 3'b000);
        chk("commit_pulses", vcnt, 1);
        chk("commit_word2", vword, 32'hCAFE_F00D);
        chk("p2tdm_en", {31'b0, p2tdm_en}, 1);
        bus(10'h100, 1'b1, 32'h8000_0000, 32'h8000_0000, 3'b000);
        chk("no_commit_pulse", vcnt, 1);
        bus(10'h100, 1'b0, 0, 32'h8000_0000, 3'b000);
        bus(10'h118, 1'b0, 0, 32'hCAFE_F00D, 3'b000);

        // saturating counters
        bus(10'h104, 1'b1, 32'hFFFE_0000, 32'hFFFE_0000, 3'b000);
        rincr = 1'b1;
        repeat (3) @(posedge clk);
        #1; rincr = 1'b0;
        bus(10'h104, 1'b0, 0, 32'hFFFF_0000, 3'b000);
        dincr = 1'b1;
        repeat (2) @(posedge clk);
        #1; dincr = 1'b0;
        bus(10'h104, 1'b0, 0, 32'hFFFF_0002, 3'b000);
        bus(10'h104, 1'b1, 32'h0, 32'h0, 3'b011);
        bus(10'h104, 1'b0, 0, 32'h0, 3'b000);

        // gain / balance
        bus(10'h20C, 1'b1, 32'h0000_3C7E, 32'h0000_3C7E, 3'b000);
        chk("gain3", {24'b0, gain[31:24]}, 32'h7E);
        chk("bal3", {24'b0, bal[31:24]}, 32'h3C);
        bus(10'h20C, 1'b0, 0, 32'h0000_3C7E, 3'b000);
        bus(10'h208, 1'b1, 32'hFFFF_1122, 32'hFFFF_1122, 3'b000);
        bus(10'h208, 1'b0, 0, 32'h0000_1122, 3'b000);

        // unmapped: val held 4 cycles gives two responses
        rc0 = ready_cnt;
        exp_q.push_back(32'hBADA_CE55);
        exp_q.push_back(32'hBADA_CE55);
        val = 1'b1; addr = 10'h220; write = 1'b0;
        repeat (4) @(posedge clk);
        #1; val = 1'b0;
        @(posedge clk); #1;
        chk("held_val_pulses", ready_cnt - rc0, 2);
        bus(10'h002, 1'b0, 0, 32'hBADA_CE55, 3'b000);
        bus(10'h030, 1'b0, 0, 32'hBADA_CE55, 3'b000);

        bus(10'h300, 1'b1, 32'h1, 32'h1, 3'b000);
        chk("sel", {31'b0, sel}, 1);
        bus(10'h300, 1'b0, 0, 32'h1, 3'b000);

`ifdef CHAN_REGS_IRQ_EN
        bus(10'h304, 1'b1, 32'h3, 32'h3, 3'b000);
        bus(10'h308, 1'b1, 32'h1, 32'h1, 3'b000);
        chk("irq_idle", {31'b0, irq}, 0);
        pulse_capture();
        chk("irq_set", {31'b0, irq}, 1);
        bus(10'h304, 1'b0, 0, 32'h1, 3'b000);
        bus(10'h304, 1'b1, 32'h1, 32'h1, 3'b000);
        chk("irq_clear", {31'b0, irq}, 0);
`else
        bus(10'h304, 1'b0, 0, 32'hBADA_CE55, 3'b000);
        pulse_capture();
        chk("irq_tied", {31'b0, irq}, 0);
`endif

        // reset drops an in-flight request
        rc0 = ready_cnt;
        rst = 1'b1; val = 1'b1; addr = 10'h000; write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; val = 1'b0;
        @(posedge clk); #1;
        chk("rst_drop_ready", ready_cnt - rc0, 0);
        chk("rst2_en_sel", {30'b0, tdm2p_en, sel}, 0);
        chk("rst2_gain", gain[31:0], 0);
        bus(10'h01C, 1'b0, 0, 32'h0, 3'b000);
        bus(10'h118, 1'b0, 0, 32'h0, 3'b000);

        repeat (2) @(posedge clk);
        #1;
        chk("pending_responses", exp_q.size(), 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
